// File: rtl/sd_sector_if.sv
// Sector handshake between a core's save/load engine (master) and a sector server (slave):
// request/ack level signals plus the sd_buff_* byte stream.
interface sd_sector_if;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din;

   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );
endinterface

// File: rtl/sd_sector_server.sv
// Serves 512-byte sector reads/writes over the sd_* handshake from a byte-wide image memory,
// and emits img_mounted pulses on request, deferred until the transfer FSM is idle.
module sd_sector_server #(
   parameter int MEM_AW    = 13,
   parameter int ACK_DELAY = 4,
   parameter int BYTE_GAP  = 0
) (
   input  logic              clk_sys,
   input  logic              RESET_n,
   sd_sector_if.slave        sd,
   input  logic              mount_req,
   output logic              img_mounted,
   output logic [31:0]       img_size,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_q,
   output logic              mem_we,
   output logic [7:0]        mem_d
);

   localparam int SEC_W = MEM_AW - 9;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_WAIT    = 4'd1;
   localparam logic [3:0] S_RD_REQ  = 4'd2;
   localparam logic [3:0] S_RD_OUT  = 4'd3;
   localparam logic [3:0] S_WR_ADDR = 4'd4;
   localparam logic [3:0] S_WR_DATA = 4'd5;
   localparam logic [3:0] S_GAP     = 4'd6;
   localparam logic [3:0] S_DONE    = 4'd7;
   localparam logic [3:0] S_HOLD    = 4'd8;

   logic [3:0]  state;
   logic [31:0] lba_q;
   logic        dir_rd;
   logic [15:0] cnt;
   logic [8:0]  idx;
   logic [8:0]  buff_addr_q;
   logic        ack_q;
   logic        mount_d;
   logic        mount_pend;
   logic        mount_rise;
   logic        in_range;
   logic        byte_done;

   assign in_range   = (lba_q >> SEC_W) == 32'd0;
   assign mount_rise = mount_req & ~mount_d;

   generate
      if (SEC_W > 0) begin : g_sec
         assign mem_addr = {lba_q[SEC_W-1:0], idx};
      end else begin : g_one
         assign mem_addr = idx;
      end
   endgenerate

   // Strobes decode straight from state so an async reset kills them in the same instant.
   assign mem_rd           = (state == S_RD_REQ) && in_range;
   assign mem_we           = (state == S_WR_DATA) && in_range;
   assign mem_d            = (state == S_WR_DATA) ? sd.sd_buff_din : 8'h00;
   assign sd.sd_buff_wr    = (state == S_RD_OUT);
   assign sd.sd_buff_dout  = (state == S_RD_OUT) ? (in_range ? mem_q : 8'hFF) : 8'h00;
   assign sd.sd_ack        = ack_q;
   assign sd.sd_buff_addr  = buff_addr_q;
   assign img_mounted      = mount_pend && (state == S_IDLE);
   assign img_size         = 32'd1 << MEM_AW;

   // A byte finishes on its second cycle, or at the end of the gap when one is configured.
   assign byte_done = ((state == S_RD_OUT || state == S_WR_DATA) && (BYTE_GAP == 0)) ||
                      ((state == S_GAP) && (cnt == 16'd0));

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state       <= S_IDLE;
         lba_q       <= 32'd0;
         dir_rd      <= 1'b0;
         cnt         <= 16'd0;
         idx         <= 9'd0;
         buff_addr_q <= 9'd0;
         ack_q       <= 1'b0;
         mount_d     <= 1'b0;
         mount_pend  <= 1'b0;
      end else begin
         mount_d <= mount_req;
         if (mount_rise)
            mount_pend <= 1'b1;

         case (state)
            S_IDLE: begin
               if (mount_pend) begin
                  // The pulse takes this cycle; a pending request is captured on the next one.
                  mount_pend <= mount_rise;
               end else if (sd.sd_rd || sd.sd_wr) begin
                  lba_q  <= sd.sd_lba;
                  dir_rd <= sd.sd_rd;
                  cnt    <= 16'(ACK_DELAY);
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 16'd0) begin
                  ack_q <= 1'b1;
                  idx   <= 9'd0;
                  if (dir_rd) begin
                     state <= S_RD_REQ;
                  end else begin
                     buff_addr_q <= 9'd0;
                     state       <= S_WR_ADDR;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_RD_REQ: begin
               buff_addr_q <= idx;
               state       <= S_RD_OUT;
            end
            S_WR_ADDR: state <= S_WR_DATA;
            S_RD_OUT, S_WR_DATA: begin
               if (BYTE_GAP != 0) begin
                  cnt   <= 16'(BYTE_GAP - 1);
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt != 16'd0)
                  cnt <= cnt - 16'd1;
            end
            S_DONE:  state <= S_HOLD;
            S_HOLD:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // Advance to the next byte, or close the sector after byte 511 without wrapping.
         if (byte_done) begin
            if (idx == 9'd511) begin
               ack_q <= 1'b0;
               state <= S_DONE;
            end else begin
               idx <= idx + 9'd1;
               if (dir_rd) begin
                  state <= S_RD_REQ;
               end else begin
                  buff_addr_q <= idx + 9'd1;
                  state       <= S_WR_ADDR;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_sector_server.sv
// Directed bench for sd_sector_server: core-side handshake driver, byte-wide image memory model,
// hand-computed expectations for latency, byte streams, range handling, reset abort and mount.
module tb_sd_sector_server;

   logic        clk_sys;
   logic        RESET_n;
   logic        mount_req;
   logic        img_mounted;
   logic [31:0] img_size;
   logic [12:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_q;
   logic        mem_we;
   logic [7:0]  mem_d;

   logic [7:0]  mem [0:8191];
   logic        load;
   logic [7:0]  din_q;

   int n_chk;
   int n_pass;

   sd_sector_if sd();

   sd_sector_server #(.MEM_AW(13), .ACK_DELAY(4), .BYTE_GAP(0)) dut (
      .clk_sys     (clk_sys),
      .RESET_n     (RESET_n),
      .sd          (sd),
      .mount_req   (mount_req),
      .img_mounted (img_mounted),
      .img_size    (img_size),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_q       (mem_q),
      .mem_we      (mem_we),
      .mem_d       (mem_d)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Image memory: preload mem[i]=i[7:0] while load is high, otherwise 1-cycle read latency.
   always @(posedge clk_sys) begin
      if (load) begin
         for (int i = 0; i < 8192; i++) mem[i] <= 8'(i);
      end else begin
         if (mem_we) mem[mem_addr] <= mem_d;
         if (mem_rd) mem_q <= mem[mem_addr];
      end
   end

   // Core write data: ~addr, presented one cycle after sd_buff_addr.
   always @(posedge clk_sys) din_q <= ~sd.sd_buff_addr[7:0];
   assign sd.sd_buff_din = din_q;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // kind: 0 expects dout=k, 1 expects ~k, 2 expects 8'hFF. mount_at<0 leaves mount_req low.
   task automatic run_sector(input logic [31:0] lba, input bit rd, input bit wr, input int kind,
                             input int mount_at, output int rise_t, output int fall_t,
                             output int nstb, output int nerr, output int nmrd, output int nmwe,
                             output int nmnt);
      bit up;
      logic [7:0] e;
      logic [7:0] k8;
      rise_t = -1; fall_t = -1; nstb = 0; nerr = 0; nmrd = 0; nmwe = 0; nmnt = 0; up = 0;
      sd.sd_lba = lba;
      sd.sd_rd  = rd;
      sd.sd_wr  = wr;
      for (int t = 1; t <= 3000; t++) begin
         @(posedge clk_sys);
         #1;
         if (sd.sd_buff_wr) begin
            k8 = nstb[7:0];
            e  = (kind == 0) ? k8 : (kind == 1) ? ~k8 : 8'hFF;
            if (sd.sd_buff_addr !== nstb[8:0] || sd.sd_buff_dout !== e || sd.sd_ack !== 1'b1)
               nerr++;
            nstb++;
         end
         if (mem_rd) nmrd++;
         if (mem_we) nmwe++;
         if (img_mounted) nmnt++;
         if (mount_at >= 0)
            mount_req = (nstb >= mount_at && nstb < mount_at + 2) ||
                        (nstb >= mount_at + 4 && nstb < mount_at + 6);
         if (!up && sd.sd_ack) begin
            up = 1; rise_t = t; sd.sd_rd = 0; sd.sd_wr = 0;
         end else if (up && !sd.sd_ack) begin
            fall_t = t;
            break;
         end
      end
      mount_req = 0;
      sd.sd_rd  = 0;
      sd.sd_wr  = 0;
   endtask

   task automatic mem_check(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 8192; i++) begin
         logic [7:0] e;
         e = (i >= 1536 && i < 2048) ? ~8'(i) : 8'(i);
         if (mem[i] !== e) bad++;
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      int rt, ft, ns, ne, nr, nw, nm;
      int tot_s, tot_e, n_to, first, np, n;
      bit hit;
      n_chk = 0; n_pass = 0;
      RESET_n = 1'b0; load = 1'b1; mount_req = 1'b0;
      sd.sd_lba = 32'd0; sd.sd_rd = 1'b0; sd.sd_wr = 1'b0;
      idle(3);
      load = 1'b0;

      chk("rst_ack", sd.sd_ack, 0);
      chk("rst_buff_addr", sd.sd_buff_addr, 0);
      chk("rst_buff_wr", sd.sd_buff_wr, 0);
      chk("rst_buff_dout", sd.sd_buff_dout, 0);
      chk("rst_img_mounted", img_mounted, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_d", mem_d, 0);
      chk("rst_img_size", img_size, 8192);
      RESET_n = 1'b1;
      idle(3);

      // Read lba 0 from idle: capture at t=1, ack at t=6, 512 strobes, ack falls at t=1030.
      run_sector(0, 1, 0, 0, -1, rt, ft, ns, ne, nr, nw, nm);
      chk("rd0_rise", rt, 6);
      chk("rd0_fall", ft, 1030);
      chk("rd0_strobes", ns, 512);
      chk("rd0_errs", ne, 0);
      chk("rd0_mem_rd", nr, 512);
      idle(3);

      // Back-to-back core loop over lba 0..15, next request issued on ack fall.
      tot_s = 0; tot_e = 0; n_to = 0;
      for (int l = 0; l < 16; l++) begin
         run_sector(l, 1, 0, 0, -1, rt, ft, ns, ne, nr, nw, nm);
         tot_s += ns; tot_e += ne;
         if (ft < 0) n_to++;
      end
      chk("loop_bytes", tot_s, 8192);
      chk("loop_errs", tot_e, 0);
      chk("loop_timeouts", n_to, 0);
      idle(3);

      // Write lba 3 with din=~addr.
      run_sector(3, 0, 1, 0, -1, rt, ft, ns, ne, nr, nw, nm);
      chk("wr3_rise", rt, 6);
      chk("wr3_fall", ft, 1030);
      chk("wr3_no_strobe", ns, 0);
      chk("wr3_mem_we", nw, 512);
      mem_check("wr3_mem");
      idle(3);

      // Out-of-range lba 16: read returns FF without touching memory, write is discarded.
      run_sector(16, 1, 0, 2, -1, rt, ft, ns, ne, nr, nw, nm);
      chk("rd16_strobes", ns, 512);
      chk("rd16_errs", ne, 0);
      chk("rd16_mem_rd", nr, 0);
      idle(3);
      run_sector(16, 0, 1, 0, -1, rt, ft, ns, ne, nr, nw, nm);
      chk("wr16_mem_we", nw, 0);
      chk("wr16_fall", ft, 1030);
      mem_check("wr16_mem");
      idle(3);

      // Both requests high: read wins, data is the ~k written earlier.
      run_sector(3, 1, 1, 1, -1, rt, ft, ns, ne, nr, nw, nm);
      chk("both_strobes", ns, 512);
      chk("both_errs", ne, 0);
      chk("both_mem_we", nw, 0);
      idle(3);

      // Two mount edges mid-read: no pulse during transfer, one pulse in first IDLE after HOLD.
      run_sector(2, 1, 0, 0, 100, rt, ft, ns, ne, nr, nw, nm);
      chk("mnt_in_xfer", nm, 0);
      chk("mnt_rd_errs", ne, 0);
      first = -1; np = 0;
      for (int t = 1; t <= 10; t++) begin
         @(posedge clk_sys);
         #1;
         if (img_mounted) begin
            if (first < 0) first = t;
            np++;
         end
      end
      chk("mnt_first_cycle", first, 2);
      chk("mnt_pulses", np, 1);
      chk("img_size", img_size, 8192);
      idle(3);

      // Reset at byte 200 of a write to lba 5.
      sd.sd_lba = 5; sd.sd_wr = 1; n = 0; hit = 0;
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk_sys);
         #1;
         if (sd.sd_ack) sd.sd_wr = 0;
         if (mem_we) n++;
         if (n == 200) begin
            hit = 1;
            break;
         end
      end
      sd.sd_wr = 0;
      chk("rst_reach_200", hit, 1);
      RESET_n = 1'b0;
      #1;
      chk("rst_ack_async", sd.sd_ack, 0);
      chk("rst_we_async", mem_we, 0);
      n = 0;
      for (int t = 0; t < 3; t++) begin
         @(posedge clk_sys);
         #1;
         n += int'(mem_we) + int'(sd.sd_buff_wr);
      end
      chk("rst_hold_addr", sd.sd_buff_addr, 0);
      RESET_n = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk_sys);
         #1;
         n += int'(mem_we) + int'(sd.sd_buff_wr);
      end
      chk("rst_no_we_after", n, 0);
      chk("rst_mem_early", mem[2570], 32'h0F5);
      chk("rst_mem_untouched", mem[2810], 32'h0FA);

      run_sector(1, 1, 0, 0, -1, rt, ft, ns, ne, nr, nw, nm);
      chk("post_rst_rise", rt, 6);
      chk("post_rst_strobes", ns, 512);
      chk("post_rst_errs", ne, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
